// File: rtl/uart_tx_scheduler.sv
// Round-robin share of one UART transmitter between two requesters, 1- or 2-byte messages, low byte first.
// Latency: request sampled at edge N -> grant pulse in N+1 -> first tx_valid in N+2 when the transmitter is free.
// Backpressure: each byte waits in SEND while i_busy is high; a byte whose valid is not answered by busy within BUSY_TO cycles is re-issued.
module uart_tx_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int BUSY_TO    = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    i_req0,
    input  logic [2*DATA_WIDTH-1:0] i_req0_data,
    input  logic                    i_req0_len2,
    output logic                    o_gnt0,
    input  logic                    i_req1,
    input  logic [2*DATA_WIDTH-1:0] i_req1_data,
    input  logic                    i_req1_len2,
    output logic                    o_gnt1,
    input  logic                    i_busy,
    output logic [DATA_WIDTH-1:0]   o_tx_data,
    output logic                    o_tx_valid,
    output logic                    o_idle
);
    localparam int CW = $clog2(BUSY_TO + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_H, WAIT_L} state_t;

    state_t                    state, state_d;
    logic [2*DATA_WIDTH-1:0]   msg_data, msg_data_d;
    logic                      msg_len2, msg_len2_d;
    logic                      byte_idx, byte_idx_d;
    logic                      last_gnt, last_gnt_d;
    logic [CW-1:0]             cnt, cnt_d;
    logic                      gnt0_d, gnt1_d, tx_valid_d, idle_d;
    logic [DATA_WIDTH-1:0]     tx_data_d;
    logic [DATA_WIDTH-1:0]     cur_byte;
    logic                      pick1;

    assign cur_byte = byte_idx ? msg_data[2*DATA_WIDTH-1:DATA_WIDTH] : msg_data[DATA_WIDTH-1:0];
    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign pick1    = i_req1 && (!i_req0 || !last_gnt);

    always_comb begin
        state_d    = state;
        msg_data_d = msg_data;
        msg_len2_d = msg_len2;
        byte_idx_d = byte_idx;
        last_gnt_d = last_gnt;
        cnt_d      = cnt;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        tx_valid_d = 1'b0;
        tx_data_d  = o_tx_data;
        case (state)
            IDLE: begin
                if (i_req0 || i_req1) begin
                    if (pick1) begin
                        msg_data_d = i_req1_data;
                        msg_len2_d = i_req1_len2;
                        gnt1_d     = 1'b1;
                        last_gnt_d = 1'b1;
                    end else begin
                        msg_data_d = i_req0_data;
                        msg_len2_d = i_req0_len2;
                        gnt0_d     = 1'b1;
                        last_gnt_d = 1'b0;
                    end
                    byte_idx_d = 1'b0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (!i_busy) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = cur_byte;
                    cnt_d      = '0;
                    state_d    = WAIT_H;
                end
            end
            WAIT_H: begin
                if (i_busy) begin
                    state_d = WAIT_L;
                end else begin
                    cnt_d = cnt + CW'(1);
                    if (cnt == CW'(BUSY_TO - 1)) begin
                        state_d = SEND;
                    end
                end
            end
            WAIT_L: begin
                if (!i_busy) begin
                    if (msg_len2 && !byte_idx) begin
                        byte_idx_d = 1'b1;
                        state_d    = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        idle_d = (state_d == IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            msg_data   <= '0;
            msg_len2   <= 1'b0;
            byte_idx   <= 1'b0;
            last_gnt   <= 1'b1;
            cnt        <= '0;
            o_gnt0     <= 1'b0;
            o_gnt1     <= 1'b0;
            o_tx_valid <= 1'b0;
            o_tx_data  <= '0;
            o_idle     <= 1'b1;
        end else begin
            state      <= state_d;
            msg_data   <= msg_data_d;
            msg_len2   <= msg_len2_d;
            byte_idx   <= byte_idx_d;
            last_gnt   <= last_gnt_d;
            cnt        <= cnt_d;
            o_gnt0     <= gnt0_d;
            o_gnt1     <= gnt1_d;
            o_tx_valid <= tx_valid_d;
            o_tx_data  <= tx_data_d;
            o_idle     <= idle_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a transmitter model answers valid pulses with busy, and a
// message-level model (round-robin winner, expected byte stream) is compared against the DUT.
module tb_uart_tx_scheduler;
    localparam int DW      = 8;
    localparam int BUSY_TO = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          i_req0 = 1'b0, i_req0_len2 = 1'b0;
    logic [2*DW-1:0] i_req0_data = '0;
    logic          i_req1 = 1'b0, i_req1_len2 = 1'b0;
    logic [2*DW-1:0] i_req1_data = '0;
    logic          i_busy = 1'b0;
    logic          o_gnt0, o_gnt1, o_tx_valid, o_idle;
    logic [DW-1:0] o_tx_data;

    uart_tx_scheduler #(.DATA_WIDTH(DW), .BUSY_TO(BUSY_TO)) dut (
        .CLK(CLK), .RST(RST),
        .i_req0(i_req0), .i_req0_data(i_req0_data), .i_req0_len2(i_req0_len2), .o_gnt0(o_gnt0),
        .i_req1(i_req1), .i_req1_data(i_req1_data), .i_req1_len2(i_req1_len2), .o_gnt1(o_gnt1),
        .i_busy(i_busy), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .o_idle(o_idle)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int nvalid = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int grant_log[$];
    int last_w = 1;
    int reraise[2] = '{0, 0};
    bit raise_pend[2] = '{0, 0};
    int tx_cnt = 0;
    int hold_len = 4;
    bit tx_arm = 0, ignore_next = 0, force_busy = 0;
    bit ign_pend = 0;
    logic [7:0] ign_byte = '0;
    int ign_cyc = 0;
    bit gnt_prev = 0, valid_prev = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, let the edge pass, then observe and play the transmitter.
    task automatic step();
        logic [1:0] s;
        logic pb;
        logic [15:0] d;
        int e, w;
        if (raise_pend[0]) begin i_req0 = 1'b1; raise_pend[0] = 0; end
        if (raise_pend[1]) begin i_req1 = 1'b1; raise_pend[1] = 0; end
        s  = {i_req1, i_req0};
        pb = i_busy;
        @(posedge CLK);
        #1;
        cyc++;
        if (o_gnt0 || o_gnt1) begin
            chk("gnt_both", {31'd0, o_gnt0 & o_gnt1}, 0);
            chk("gnt_repeat", {31'd0, gnt_prev}, 0);
            chk("gnt_idle_low", {31'd0, o_idle}, 0);
            chk("gnt_had_req", {31'd0, s != 2'b00}, 1);
            e = (s == 2'b11) ? (1 - last_w) : (s[1] ? 1 : 0);
            w = o_gnt1 ? 1 : 0;
            chk("gnt_winner", w, e);
            last_w = e;
            grant_log.push_back(w);
            d = (e == 1) ? i_req1_data : i_req0_data;
            exp_q.push_back(d[7:0]);
            if ((e == 1) ? i_req1_len2 : i_req0_len2) exp_q.push_back(d[15:8]);
            if (w == 0) i_req0 = 1'b0; else i_req1 = 1'b0;
            if (reraise[w] > 0) begin reraise[w]--; raise_pend[w] = 1; end
        end
        gnt_prev = o_gnt0 | o_gnt1;
        if (tx_arm) begin tx_cnt = hold_len; tx_arm = 0; end
        i_busy = force_busy || (tx_cnt > 0);
        if (tx_cnt > 0) tx_cnt--;
        if (o_tx_valid) begin
            nvalid++;
            chk("valid_repeat", {31'd0, valid_prev}, 0);
            chk("valid_while_busy", {31'd0, pb}, 0);
            if (ign_pend) begin
                chk("reissue_byte", o_tx_data, ign_byte);
                chk("reissue_gap", cyc - ign_cyc, BUSY_TO + 1);
                ign_pend = 0;
            end
            if (ignore_next) begin
                ignore_next = 0;
                ign_pend = 1;
                ign_byte = o_tx_data;
                ign_cyc = cyc;
            end else begin
                got_q.push_back(o_tx_data);
                tx_arm = 1;
            end
        end
        valid_prev = o_tx_valid;
    endtask

    task automatic wait_done(input int budget);
        bit done;
        done = 0;
        for (int k = 0; k < budget; k++) begin
            if (o_idle && !i_req0 && !i_req1 && tx_cnt == 0 && !tx_arm &&
                !raise_pend[0] && !raise_pend[1] && !ign_pend) begin
                done = 1;
                break;
            end
            step();
        end
        if (!done) chk("timeout", 0, 1);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_byte"}, got_q[i], exp_q[i]);
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        int n0, vsum;
        bit got_one;
        int m;

        // Reset state
        RST = 1'b1;
        step();
        step();
        chk("rst_idle", {31'd0, o_idle}, 1);
        chk("rst_gnt0", {31'd0, o_gnt0}, 0);
        chk("rst_gnt1", {31'd0, o_gnt1}, 0);
        chk("rst_valid", {31'd0, o_tx_valid}, 0);
        chk("rst_data", o_tx_data, 0);
        RST = 1'b0;
        step();

        // Single-byte message from requester 0, exact latency
        hold_len = 10;
        i_req0_data = 16'hBEEF; i_req0_len2 = 1'b0; i_req0 = 1'b1;
        n0 = nvalid;
        step();
        chk("t1_gnt0", {31'd0, o_gnt0}, 1);
        chk("t1_idle_low", {31'd0, o_idle}, 0);
        step();
        chk("t1_valid", {31'd0, o_tx_valid}, 1);
        chk("t1_byte", o_tx_data, 8'hEF);
        wait_done(100);
        chk("t1_idle", {31'd0, o_idle}, 1);
        chk("t1_nvalid", nvalid - n0, 1);
        check_stream("t1");

        // Two-byte message from requester 1, low byte first
        hold_len = 6;
        i_req1_data = 16'h1234; i_req1_len2 = 1'b1; i_req1 = 1'b1;
        n0 = nvalid;
        wait_done(200);
        chk("t2_nvalid", nvalid - n0, 2);
        chk("t2_gnt1", grant_log[grant_log.size()-1], 1);
        check_stream("t2");

        // Both requesting, each re-raised once: strict alternation
        grant_log.delete();
        hold_len = 3;
        i_req0_data = 16'($urandom); i_req0_len2 = 1'($urandom);
        i_req1_data = 16'($urandom); i_req1_len2 = 1'($urandom);
        reraise[0] = 1; reraise[1] = 1;
        i_req0 = 1'b1; i_req1 = 1'b1;
        wait_done(400);
        chk("t3_ngrants", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk("t3_order", grant_log[i], i % 2);
        check_stream("t3");

        // Transmitter busy at grant time: no valid until busy drops
        force_busy = 1; i_busy = 1'b1;
        i_req0_data = 16'($urandom); i_req0_len2 = 1'b0; i_req0 = 1'b1;
        step();
        chk("t4_gnt0", {31'd0, o_gnt0}, 1);
        vsum = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            vsum += int'(o_tx_valid);
        end
        chk("t4_no_valid", vsum, 0);
        force_busy = 0; i_busy = 1'b0;
        step();
        chk("t4_valid_now", {31'd0, o_tx_valid}, 1);
        wait_done(100);
        check_stream("t4");

        // First valid ignored by the transmitter: same byte re-issued after the timeout
        hold_len = 5;
        ignore_next = 1;
        i_req1_data = 16'($urandom); i_req1_len2 = 1'b0; i_req1 = 1'b1;
        n0 = nvalid;
        wait_done(200);
        chk("t5_nvalid", nvalid - n0, 2);
        check_stream("t5");

        // Reset while waiting for busy to fall on byte 0 of a 2-byte message
        hold_len = 12;
        i_req0_data = 16'($urandom); i_req0_len2 = 1'b1; i_req0 = 1'b1;
        got_one = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (got_q.size() == 1) begin got_one = 1; break; end
        end
        chk("t6_first_byte", {31'd0, got_one}, 1);
        step(); step(); step();
        chk("t6_busy_phase", {31'd0, o_idle}, 0);
        RST = 1'b1;
        step();
        chk("t6_rst_idle", {31'd0, o_idle}, 1);
        chk("t6_rst_gnt0", {31'd0, o_gnt0}, 0);
        chk("t6_rst_gnt1", {31'd0, o_gnt1}, 0);
        chk("t6_rst_valid", {31'd0, o_tx_valid}, 0);
        chk("t6_rst_data", o_tx_data, 0);
        RST = 1'b0;
        last_w = 1;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        n0 = nvalid;
        for (int i = 0; i < 20; i++) step();
        chk("t6_no_byte1", nvalid - n0, 0);
        check_stream("t6");

        // Randomized message mix against the model
        for (int it = 0; it < 40; it++) begin
            m = $urandom_range(1, 3);
            hold_len = $urandom_range(1, 6);
            ignore_next = ($urandom_range(0, 4) == 0);
            if (m[0]) begin
                i_req0_data = 16'($urandom); i_req0_len2 = 1'($urandom); i_req0 = 1'b1;
            end
            if (m[1]) begin
                i_req1_data = 16'($urandom); i_req1_len2 = 1'($urandom); i_req1 = 1'b1;
            end
            wait_done(300);
            check_stream("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
